// File: rtl/pf_vf_rtable_lookup.sv
// Runtime-programmable PF/VF routing table: two-stage lookup of {pf, vf, vf_active}
// against a CSR-writable entry table, returning the mux port ID of the lowest matching entry.
module pf_vf_rtable_lookup #(
    parameter int NUM_PORT    = 2,
    parameter int NUM_ENTRIES = NUM_PORT + 2,
    parameter int PF_WIDTH    = 3,
    parameter int VF_WIDTH    = 12,
    parameter int PID_WIDTH   = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1,
    parameter int IDX_WIDTH   = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    parameter int DEFAULT_PID = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [PF_WIDTH-1:0]                   in_pf,
    input  logic [VF_WIDTH-1:0]                   in_vf,
    input  logic                                  in_vf_active,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [PID_WIDTH-1:0]                  out_pid,
    output logic                                  out_hit,
    output logic [IDX_WIDTH-1:0]                  out_idx,
    input  logic                                  cfg_wr_en,
    input  logic [IDX_WIDTH-1:0]                  cfg_wr_idx,
    input  logic [PF_WIDTH+VF_WIDTH+PID_WIDTH+3:0] cfg_wr_data,
    input  logic [IDX_WIDTH-1:0]                  cfg_rd_idx,
    output logic [PF_WIDTH+VF_WIDTH+PID_WIDTH+3:0] cfg_rd_data,
    output logic                                  cfg_err,
    output logic [15:0]                           miss_cnt
);

    localparam int EW      = PF_WIDTH + VF_WIDTH + PID_WIDTH + 4;
    localparam int VF_LSB  = PID_WIDTH;
    localparam int PF_LSB  = PID_WIDTH + VF_WIDTH;
    localparam int VA_BIT  = EW - 4;
    localparam int VFW_BIT = EW - 3;
    localparam int PFW_BIT = EW - 2;
    localparam int EN_BIT  = EW - 1;
    localparam logic [PID_WIDTH-1:0] DEF_PID = PID_WIDTH'(DEFAULT_PID);

    logic [EW-1:0]          table_q   [NUM_ENTRIES];
    logic [PID_WIDTH-1:0]   entry_pid [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] match_vec;
    logic [NUM_ENTRIES-1:0] wr_sel;
    logic [NUM_ENTRIES-1:0] rd_sel;

    // One register per entry so each can carry its own reset value from the default map.
    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            localparam logic [EW-1:0] RESET_ENTRY = (gi < NUM_PORT) ?
                {4'b1000, PF_WIDTH'(gi), VF_WIDTH'(0), PID_WIDTH'(gi)} :
                {3'b111, 1'(gi == NUM_ENTRIES - 1), {(PF_WIDTH + VF_WIDTH + PID_WIDTH){1'b0}}};

            logic [EW-1:0] entry_reg;

            assign wr_sel[gi] = (cfg_wr_idx == IDX_WIDTH'(gi));
            assign rd_sel[gi] = (cfg_rd_idx == IDX_WIDTH'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= RESET_ENTRY;
                end else if (cfg_wr_en && wr_sel[gi]) begin
                    entry_reg <= cfg_wr_data;
                end
            end

            assign table_q[gi]   = entry_reg;
            assign entry_pid[gi] = entry_reg[PID_WIDTH-1:0];
            assign match_vec[gi] = entry_reg[EN_BIT]
                && (entry_reg[VA_BIT] == in_vf_active)
                && (entry_reg[PFW_BIT] || (entry_reg[PF_LSB +: PF_WIDTH] == in_pf))
                && (entry_reg[VFW_BIT] || (entry_reg[VF_LSB +: VF_WIDTH] == in_vf));
        end
    endgenerate

    // An index that selects no entry is out of range: reads return 0, writes flag cfg_err.
    logic [EW-1:0] rd_mux;
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (rd_sel[i]) begin
                rd_mux = rd_mux | table_q[i];
            end
        end
    end

    logic                   s1_valid_reg;
    logic [NUM_ENTRIES-1:0] s1_match_reg;
    logic [PID_WIDTH-1:0]   s1_pid_reg [NUM_ENTRIES];
    logic                   s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid_reg || s2_adv;

    logic                 pe_hit;
    logic [IDX_WIDTH-1:0] pe_idx;
    logic [PID_WIDTH-1:0] pe_pid;
    always_comb begin
        pe_hit = 1'b0;
        pe_idx = '0;
        pe_pid = DEF_PID;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (s1_match_reg[i]) begin
                pe_hit = 1'b1;
                pe_idx = IDX_WIDTH'(i);
                pe_pid = s1_pid_reg[i];
            end
        end
    end

    // S1 snapshots the PIDs with the match vector so later table writes cannot alter in-flight results.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_match_reg <= '0;
            s1_pid_reg   <= '{default: '0};
            out_valid    <= 1'b0;
            out_hit      <= 1'b0;
            out_pid      <= '0;
            out_idx      <= '0;
            cfg_rd_data  <= '0;
            cfg_err      <= 1'b0;
            miss_cnt     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_match_reg <= match_vec;
                    s1_pid_reg   <= entry_pid;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_hit <= pe_hit;
                    out_idx <= pe_idx;
                    out_pid <= pe_pid;
                end
            end
            cfg_rd_data <= rd_mux;
            cfg_err     <= cfg_wr_en && !(|wr_sel);
            if (out_valid && out_ready && !out_hit && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pf_vf_rtable_lookup.sv
// Bench for pf_vf_rtable_lookup: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based behavioural model of the routing table.
module tb_pf_vf_rtable_lookup;

    localparam int NP   = 2;
    localparam int NE   = 5;
    localparam int PIDW = 1;
    localparam int IDXW = 3;
    localparam int EW   = 20;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_pf = '0;
    logic [11:0]     in_vf = '0;
    logic            in_vf_active = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [PIDW-1:0] out_pid;
    logic            out_hit;
    logic [IDXW-1:0] out_idx;
    logic            cfg_wr_en = 1'b0;
    logic [IDXW-1:0] cfg_wr_idx = '0;
    logic [EW-1:0]   cfg_wr_data = '0;
    logic [IDXW-1:0] cfg_rd_idx = '0;
    logic [EW-1:0]   cfg_rd_data;
    logic            cfg_err;
    logic [15:0]     miss_cnt;

    pf_vf_rtable_lookup #(.NUM_PORT(NP), .NUM_ENTRIES(NE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pf(in_pf), .in_vf(in_vf), .in_vf_active(in_vf_active),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pid(out_pid), .out_hit(out_hit), .out_idx(out_idx),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_data(cfg_wr_data),
        .cfg_rd_idx(cfg_rd_idx), .cfg_rd_data(cfg_rd_data),
        .cfg_err(cfg_err), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PIDW-1:0] pid;
        logic            hit;
        logic [IDXW-1:0] idx;
        int              acc;
    } res_t;

    res_t        q[$];
    logic [EW-1:0] mtab [NE];
    logic [EW-1:0] exp_rd;
    logic        exp_err;
    logic [15:0] exp_miss;
    bit          rst_seen = 0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NE; i++) begin
            if (i < NP) mtab[i] = {4'b1000, 3'(i), 12'd0, 1'(i)};
            else        mtab[i] = {3'b111, 1'(i == NE - 1), 16'd0};
        end
    endfunction

    // Fields: [19] en, [18] pf_wild, [17] vf_wild, [16] vf_active, [15:13] pf, [12:1] vf, [0] pid.
    function automatic res_t lookup(input logic [2:0] pf, input logic [11:0] vf, input logic va);
        res_t r;
        r.hit = 1'b0; r.pid = '0; r.idx = '0; r.acc = 0;
        for (int i = 0; i < NE; i++) begin
            logic [EW-1:0] e;
            e = mtab[i];
            if (!r.hit && e[19] && e[16] == va && (e[18] || e[15:13] == pf) && (e[17] || e[12:1] == vf)) begin
                r.hit = 1'b1;
                r.pid = e[0];
                r.idx = IDXW'(i);
            end
        end
        return r;
    endfunction

    // Called on the falling edge: check outputs, then fold in what the next rising edge will do.
    task automatic step();
        res_t r;
        if (rst_seen) begin
            chk("cfg_err", 32'(cfg_err), 32'(exp_err));
            chk("cfg_rd_data", 32'(cfg_rd_data), 32'(exp_rd));
            chk("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
            if (!rst) chk("in_ready", 32'(in_ready), 32'(q.size() < 2 || out_ready));
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0 && cyc >= q[0].acc + 2));
            if (out_valid && q.size() > 0) begin
                chk("out_pid", 32'(out_pid), 32'(q[0].pid));
                chk("out_hit", 32'(out_hit), 32'(q[0].hit));
                chk("out_idx", 32'(out_idx), 32'(q[0].idx));
                if (out_ready) begin
                    if (!q[0].hit && exp_miss != 16'hFFFF) exp_miss = exp_miss + 16'd1;
                    void'(q.pop_front());
                end
            end
        end
        if (rst) begin
            model_reset();
            q.delete();
            exp_err  = 1'b0;
            exp_rd   = '0;
            exp_miss = '0;
            rst_seen = 1;
            return;
        end
        if (in_valid && in_ready) begin
            r = lookup(in_pf, in_vf, in_vf_active);
            r.acc = cyc;
            q.push_back(r);
        end
        exp_rd  = (cfg_rd_idx < NE) ? mtab[cfg_rd_idx] : '0;
        exp_err = cfg_wr_en && (cfg_wr_idx >= NE);
        if (cfg_wr_en && cfg_wr_idx < NE) mtab[cfg_wr_idx] = cfg_wr_data;
    endtask

    task automatic tick();
        @(negedge clk);
        step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input logic v, input logic [2:0] pf, input logic [11:0] vf, input logic va);
        in_valid = v; in_pf = pf; in_vf = vf; in_vf_active = va;
    endtask

    // Single request into an empty pipeline; returns with its result on the outputs.
    task automatic do_req(input logic [2:0] pf, input logic [11:0] vf, input logic va);
        set_req(1'b1, pf, vf, va);
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    int acc_cnt;

    initial begin
        repeat (3) tick();
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_hit", 32'(out_hit), 0);
        chk("rst out_pid", 32'(out_pid), 0);
        chk("rst out_idx", 32'(out_idx), 0);
        chk("rst cfg_rd_data", 32'(cfg_rd_data), 0);
        chk("rst cfg_err", 32'(cfg_err), 0);
        chk("rst miss_cnt", 32'(miss_cnt), 0);
        rst = 1'b0;
        tick();
        chk("in_ready after rst", 32'(in_ready), 1);

        // Identity entry 1
        do_req(3'd1, 12'd0, 1'b1 ^ 1'b1);
        chk("id1 valid", 32'(out_valid), 1);
        chk("id1 pid", 32'(out_pid), 1);
        chk("id1 hit", 32'(out_hit), 1);
        chk("id1 idx", 32'(out_idx), 1);
        tick();

        // vf_active catch-all lives in the last entry
        do_req(3'd5, 12'd7, 1'b1);
        chk("va hit", 32'(out_hit), 1);
        chk("va idx", 32'(out_idx), NE - 1);
        chk("va pid", 32'(out_pid), 0);
        tick();

        // Disable it: the same request now misses
        cfg_wr_en = 1'b1; cfg_wr_idx = 3'd4; cfg_wr_data = '0;
        tick();
        cfg_wr_en = 1'b0;
        do_req(3'd5, 12'd7, 1'b1);
        chk("miss hit", 32'(out_hit), 0);
        chk("miss pid", 32'(out_pid), 0);
        chk("miss idx", 32'(out_idx), 0);
        tick();
        chk("miss_cnt one", 32'(miss_cnt), 1);

        // Write entry 0 pid=1 in the same cycle as a request, then one more
        cfg_wr_en = 1'b1; cfg_wr_idx = 3'd0; cfg_wr_data = 20'h80001;
        set_req(1'b1, 3'd0, 12'd0, 1'b0);
        tick();
        cfg_wr_en = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("wr old pid", 32'(out_pid), 0);
        chk("wr old idx", 32'(out_idx), 0);
        tick();
        chk("wr new pid", 32'(out_pid), 1);
        tick();

        // Stall the output with back-to-back requests
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 3'(i % 2), 12'd0, 1'b0);
            if (in_ready) acc_cnt++;
            tick();
        end
        chk("stall accepted", 32'(acc_cnt), 2);
        chk("stall in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (4) tick();

        // Out-of-range write
        cfg_wr_en = 1'b1; cfg_wr_idx = 3'd5; cfg_wr_data = '0;
        tick();
        cfg_wr_en = 1'b0;
        chk("oob cfg_err", 32'(cfg_err), 1);
        cfg_rd_idx = 3'd1;
        tick();
        chk("oob pulse end", 32'(cfg_err), 0);
        chk("entry1 intact", 32'(cfg_rd_data), 32'h82001);
        cfg_rd_idx = 3'd6;
        tick();
        chk("oob read", 32'(cfg_rd_data), 0);

        // Reset with both stages full
        out_ready = 1'b0;
        set_req(1'b1, 3'd1, 12'd0, 1'b0);
        repeat (2) tick();
        in_valid = 1'b0;
        chk("full before rst", 32'(out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("rst flush", 32'(out_valid), 0);
        cfg_rd_idx = 3'd4;
        tick();
        chk("entry4 restored", 32'(cfg_rd_data), 32'hF0000);
        cfg_rd_idx = 3'd0;
        tick();
        chk("entry0 restored", 32'(cfg_rd_data), 32'h80000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 599) == 0);
            in_valid     = ($urandom_range(0, 3) != 0);
            in_pf        = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
            in_vf        = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 2));
            in_vf_active = 1'($urandom);
            out_ready    = ($urandom_range(0, 9) < 7);
            cfg_wr_en    = ($urandom_range(0, 9) == 0);
            cfg_wr_idx   = 3'($urandom);
            cfg_wr_data  = {($urandom_range(0, 4) != 0), 3'($urandom), 3'($urandom_range(0, 1)),
                            12'($urandom_range(0, 2)), 1'($urandom)};
            cfg_rd_idx   = 3'($urandom);
            tick();
        end

        rst = 1'b0; in_valid = 1'b0; cfg_wr_en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        chk("drain", 32'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
